// File: rtl/ntt_butterfly_pipe_pkg.sv
// Shared definitions for the Z_q butterfly pipeline (q = 3329).
//   - modulus / width / Barrett constants
//   - per-beat mode encoding
//   - stage payload structs
//   - single-correction modular add/sub helpers for operands in [0, Q-1]
package ntt_butterfly_pipe_pkg;

  localparam int unsigned Q         = 3329;
  localparam int unsigned W         = 12;
  localparam int unsigned BARRETT_K = 24;
  localparam int unsigned BARRETT_M = 5039;   // floor(2^24 / Q)
  localparam int unsigned PW        = 2 * W;  // product width

  typedef enum logic {
    MODE_NTT  = 1'b0,
    MODE_INTT = 1'b1
  } mode_e;

  // S1: x = a (NTT) or s (INTT); y = b (NTT) or d (INTT)
  typedef struct packed {
    mode_e         mode;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [W-1:0]  w;
  } s1_t;

  // S2: product waiting for reduction
  typedef struct packed {
    mode_e         mode;
    logic [W-1:0]  x;
    logic [PW-1:0] p;
  } s2_t;

  // S3: reduced product
  typedef struct packed {
    mode_e         mode;
    logic [W-1:0]  x;
    logic [W-1:0]  r;
  } s3_t;

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (W+1)'(Q)) s = s - (W+1)'(Q);
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b};
    // wrap-around of the 13-bit difference is harmless: adding Q brings the
    // low bits back into [1, Q-1]
    if (a < b) d = d + (W+1)'(Q);
    return d[W-1:0];
  endfunction

endpackage

// File: rtl/ntt_butterfly_pipe_barrett_reduce_q.sv
// Combinational Barrett reduction of a 24-bit product modulo Q.
//   p : product, p < 2^24
//   r : p mod Q, in [0, Q-1]
// The quotient estimate is at most one short, so r = p - t*Q lies in
// [0, 2Q) and fits 13 bits; only the low 13 bits of p and t*Q are needed.
module barrett_reduce_q
  import ntt_butterfly_pipe_pkg::*;
(
  input  logic [PW-1:0] p,
  output logic [W-1:0]  r
);

  localparam int unsigned MW  = 13;        // width of BARRETT_M
  localparam int unsigned PMW = PW + MW;

  logic [PMW-1:0] pm;
  logic [W:0]     t;
  logic [W:0]     tq;
  logic [W:0]     r_raw;
  logic [W:0]     r_fix;

  always_comb begin
    pm    = PMW'(p) * PMW'(BARRETT_M);
    t     = (W+1)'(pm >> BARRETT_K);
    tq    = (W+1)'(t * (W+1)'(Q));
    r_raw = p[W:0] - tq;
    r_fix = (r_raw >= (W+1)'(Q)) ? r_raw - (W+1)'(Q) : r_raw;
    r     = r_fix[W-1:0];
  end

endmodule

// File: rtl/ntt_butterfly_pipe.sv
// Pipelined modular butterfly over Z_3329, 4 register stages, 1 beat/cycle.
//   in_valid/in_ready/in_a/in_b/in_w/NTT_INTT_sel : input beat
//     NTT_INTT_sel = 0 : a' = a + w*b, b' = a - w*b            (CT)
//     NTT_INTT_sel = 1 : a' = a + b,   b' = (a - b) * w        (GS)
//   out_valid/out_ready/out_a/out_b                : output beat
// Flow control is a global stall: when the output beat is not taken, every
// stage holds and in_ready drops combinationally.
module ntt_butterfly_pipe
  import ntt_butterfly_pipe_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_w,
  input  logic         NTT_INTT_sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b
);

  localparam int STAGES = 4;

  logic              stall;
  logic [STAGES:1]   vld_pipe_q, vld_pipe_d;
  s1_t               s1_q, s1_d;
  s2_t               s2_q, s2_d;
  s3_t               s3_q, s3_d;
  logic [W-1:0]      out_a_q, out_a_d;
  logic [W-1:0]      out_b_q, out_b_d;
  logic [W-1:0]      r_red;
  mode_e             in_mode;

  assign stall     = vld_pipe_q[STAGES] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_pipe_q[STAGES];
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign in_mode   = mode_e'(NTT_INTT_sel);

  barrett_reduce_q u_red (
    .p (s2_q.p),
    .r (r_red)
  );

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    s3_d       = s3_q;
    out_a_d    = out_a_q;
    out_b_d    = out_b_q;
    if (!stall) begin
      // bubbles enter as valid=0; data regs still advance, values unused
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};

      s1_d.mode  = in_mode;
      s1_d.x     = (in_mode == MODE_INTT) ? mod_add(in_a, in_b) : in_a;
      s1_d.y     = (in_mode == MODE_INTT) ? mod_sub(in_a, in_b) : in_b;
      s1_d.w     = in_w;

      s2_d.mode  = s1_q.mode;
      s2_d.x     = s1_q.x;
      s2_d.p     = PW'(s1_q.w) * PW'(s1_q.y);

      s3_d.mode  = s2_q.mode;
      s3_d.x     = s2_q.x;
      s3_d.r     = r_red;

      out_a_d    = (s3_q.mode == MODE_NTT) ? mod_add(s3_q.x, s3_q.r) : s3_q.x;
      out_b_d    = (s3_q.mode == MODE_NTT) ? mod_sub(s3_q.x, s3_q.r) : s3_q.r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      out_a_q    <= '0;
      out_b_q    <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      out_a_q    <= out_a_d;
      out_b_q    <= out_b_d;
    end
  end

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// Self-checking bench for ntt_butterfly_pipe: scoreboard of expected output
// pairs filled at input handshake, drained by an output monitor.
module tb_ntt_butterfly_pipe;

  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_a = '0, in_b = '0, in_w = '0;
  logic        NTT_INTT_sel = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_a, out_b;

  ntt_butterfly_pipe dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_w         (in_w),
    .NTT_INTT_sel (NTT_INTT_sel),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_a        (out_a),
    .out_b        (out_b)
  );

  always #5 clk = ~clk;

  typedef struct { int a; int b; bit dc; } exp_t;

  exp_t sb[$];
  int   out_cyc[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   hs_cyc  = 0;
  bit   mon_en  = 1'b0;
  bit   hold_chk = 1'b0;
  logic [11:0] hold_a, hold_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  function automatic exp_t ref_bf(input int a, input int b, input int w, input bit m);
    exp_t e;
    int   wb;
    e.dc = 1'b0;
    if (!m) begin
      wb  = (w * b) % Q;
      e.a = (a + wb) % Q;
      e.b = (a - wb + Q) % Q;
    end else begin
      e.a = (a + b) % Q;
      e.b = (((a - b + Q) % Q) * w) % Q;
    end
    return e;
  endfunction

  // Drive a beat at posedge+1; the negedge decides whether the next posedge
  // is the handshake, at which point the expectation is queued.
  task automatic send(input int a, input int b, input int w, input bit m, input exp_t e);
    int t = 0;
    in_valid = 1'b1; in_a = 12'(a); in_b = 12'(b); in_w = 12'(w); NTT_INTT_sel = m;
    @(negedge clk);
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    hs_cyc = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_ref(input int a, input int b, input int w, input bit m);
    send(a, b, w, m, ref_bf(a, b, w, m));
  endtask

  task automatic send_rand(input bit m);
    send_ref($urandom_range(0, Q-1), $urandom_range(0, Q-1), $urandom_range(0, Q-1), m);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin @(negedge clk); t++; end
    chk("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Output monitor: sampled on negedge, so out_valid&out_ready seen here is
  // the handshake that the following posedge completes.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (hold_chk) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_a", out_a, hold_a);
        chk("hold_b", out_b, hold_b);
      end
      hold_chk = 1'b0;
      if (out_valid && !out_ready) begin
        chk("in_ready_stall", in_ready, 0);
        hold_chk = 1'b1;
        hold_a   = out_a;
        hold_b   = out_b;
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          if (!e.dc) begin
            chk("out_a", out_a, e.a);
            chk("out_b", out_b, e.b);
          end
          out_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    exp_t e;
    int   idx;
    bit   done;

    // reset state
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_b", out_b, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // directed vectors with hand-computed results
    e = '{a: 35, b: 3296, dc: 1'b0};
    send(1, 2, 17, 1'b0, e);
    drain();
    chk("lat_ntt", out_cyc[out_cyc.size()-1] - hs_cyc, 4);
    e = '{a: 3, b: 3312, dc: 1'b0};
    send(1, 2, 17, 1'b1, e);
    drain();
    chk("lat_intt", out_cyc[out_cyc.size()-1] - hs_cyc, 4);
    e = '{a: 0, b: 3327, dc: 1'b0};
    send(3328, 3328, 3328, 1'b0, e);
    e = '{a: 3327, b: 0, dc: 1'b0};
    send(3328, 3328, 3328, 1'b1, e);
    e = '{a: 0, b: 0, dc: 1'b0};
    send(0, 0, 0, 1'b0, e);
    drain();

    // 16 back-to-back beats, alternating mode
    idx = out_cyc.size();
    for (int i = 0; i < 16; i++) send_rand(i[0]);
    drain();
    chk("burst_count", out_cyc.size() - idx, 16);
    chk("burst_span", out_cyc[out_cyc.size()-1] - out_cyc[idx], 15);

    // 6-cycle output stall while streaming
    idx = out_cyc.size();
    fork
      begin
        for (int i = 0; i < 12; i++) send_rand(1'($urandom_range(0, 1)));
      end
      begin
        int t = 0;
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_count", out_cyc.size() - idx, 12);

    // random backpressure, random modes
    idx = out_cyc.size();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) send_rand(1'($urandom_range(0, 1)));
        done = 1'b1;
      end
      begin
        while (!done) begin @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1)); end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("rand_count", out_cyc.size() - idx, 24);

    // out-of-range operands: value is don't-care, pipeline must keep moving
    e = '{a: 0, b: 0, dc: 1'b1};
    send(4095, 4095, 4095, 1'b0, e);
    send(4095, 4095, 4095, 1'b1, e);
    send_ref(5, 7, 11, 1'b0);
    drain();

    // reset with beats in flight: out_valid high, three more behind it
    for (int i = 0; i < 5; i++) send_ref(100 + i, 200 + i, 300 + i, i[0]);
    chk("pre_rst_valid", out_valid, 1);
    mon_en = 1'b0;
    hold_chk = 1'b0;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_a", out_a, 0);
    chk("mid_rst_out_b", out_b, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_hold_valid", out_valid, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    e = '{a: 35, b: 3296, dc: 1'b0};
    send(1, 2, 17, 1'b0, e);
    drain();
    chk("lat_post_rst", out_cyc[out_cyc.size()-1] - hs_cyc, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles, want completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
